// File: rtl/bram_uart_loader.sv
// bram_uart_loader
//   Receives a CR16 program image over an 8N1 UART line and writes it, one
//   16-bit word at a time, into BRAM starting at address 0. When the image is
//   complete O_DONE rises; the top level uses it to release the processor.
//
//   Image byte stream: N[15:8], N[7:0], then N words, each high byte first.
//   With BRAM_LOADER_CHECKSUM_EN defined, one extra byte follows the image and
//   must equal the XOR of every preceding byte, including the two count bytes.
//
// Ports
//   I_CLK               system clock, everything on posedge
//   I_NRESET            asynchronous active-low reset
//   I_UART_RX           serial input, idle high, LSB first
//   O_MEM_DATA          word being written
//   O_MEM_ADDRESS       write address (wraps modulo 2^P_ADDRESS_WIDTH)
//   O_MEM_WRITE_ENABLE  one-cycle write strobe
//   O_LOADING           high from the first header start bit until done/error
//   O_DONE              image written, sticky until reset
//   O_ERROR             framing/length/checksum fault, sticky until reset
//   O_WORD_COUNT        words written so far
//   O_DBG_STATE         loader FSM state, for observation only
//
// Internal byte handshake: the receiver raises rx_valid_q for exactly one
// cycle with rx_byte_q stable in that cycle. There is no ready; the loader
// always consumes the byte in the cycle it is valid (or ignores it when in a
// terminal state).
module bram_uart_loader #(
  parameter int P_CLK_FREQ_HZ   = 50_000_000,
  parameter int P_BAUD_RATE     = 115200,
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_LOADING,
  output logic                       O_DONE,
  output logic                       O_ERROR,
  output logic [15:0]                O_WORD_COUNT,
  output logic [2:0]                 O_DBG_STATE
);

  localparam int          L_DIV       = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam logic [15:0] L_FULL_M1   = 16'(L_DIV - 1);
  localparam logic [15:0] L_HALF_M1   = 16'((L_DIV / 2) - 1);
  localparam logic [16:0] L_MAX_WORDS = 17'(2 ** P_ADDRESS_WIDTH);

  // ---------------------------------------------------------------------
  // RX synchronizer; reset to the idle level so reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= I_UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;

  // Decoded from registers so the loader can react in the sample cycle
  // itself: error then rises one cycle after the bad stop-bit sample.
  logic rx_frame_err;
  logic rx_start_ok;
  assign rx_frame_err = (rx_state_q == R_STOP) && (rx_cnt_q == L_FULL_M1) && !rx_sync_q;
  assign rx_start_ok  = (rx_state_q == R_START) && (rx_cnt_q == L_HALF_M1) && !rx_sync_q;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= R_START;
            rx_cnt_q   <= '0;
          end
        end
        R_START: begin
          if (rx_cnt_q == L_HALF_M1) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // Line back high at mid-start: a glitch, not a start bit.
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == L_FULL_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == L_FULL_M1) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
            if (rx_sync_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Image loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_CNT_HI  = 3'd0,
    S_CNT_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_FINISH  = 3'd4,  // cycle of the final strobe; done follows it
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t                     state_q;
  logic [7:0]                 cnt_hi_q;
  logic [15:0]                words_left_q;
  logic [7:0]                 xor_q;
  logic [P_DATA_WIDTH-1:0]    data_q;
  logic [P_ADDRESS_WIDTH-1:0] addr_q;
  logic                       we_q;
  logic                       loading_q;
  logic                       done_q;
  logic                       error_q;
  logic [15:0]                wcnt_q;

  logic [15:0] hdr_count;
  assign hdr_count = {cnt_hi_q, rx_byte_q};

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q      <= S_CNT_HI;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      xor_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      we_q <= 1'b0;
      // Address and count advance in the cycle after the strobe.
      if (we_q) begin
        addr_q <= addr_q + 1'b1;
        wcnt_q <= wcnt_q + 16'd1;
      end
      case (state_q)
        S_CNT_HI: begin
          if (rx_start_ok) loading_q <= 1'b1;
          if (rx_valid_q) begin
            cnt_hi_q <= rx_byte_q;
            xor_q    <= xor_q ^ rx_byte_q;
            state_q  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (rx_valid_q) begin
            xor_q <= xor_q ^ rx_byte_q;
            if (hdr_count == 16'd0) begin
`ifdef BRAM_LOADER_CHECKSUM_EN
              state_q <= S_CHECK;
`else
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              loading_q <= 1'b0;
`endif
            end else if ({1'b0, hdr_count} > L_MAX_WORDS) begin
              state_q   <= S_ERROR;
              error_q   <= 1'b1;
              loading_q <= 1'b0;
            end else begin
              words_left_q <= hdr_count;
              state_q      <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (rx_valid_q) begin
            data_q[15:8] <= rx_byte_q;
            xor_q        <= xor_q ^ rx_byte_q;
            state_q      <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (rx_valid_q) begin
            data_q[7:0]  <= rx_byte_q;
            xor_q        <= xor_q ^ rx_byte_q;
            we_q         <= 1'b1;
            words_left_q <= words_left_q - 16'd1;
            state_q      <= (words_left_q == 16'd1) ? S_FINISH : S_DATA_HI;
          end
        end
        S_FINISH: begin
`ifdef BRAM_LOADER_CHECKSUM_EN
          state_q <= S_CHECK;
`else
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          loading_q <= 1'b0;
`endif
        end
        S_CHECK: begin
          if (rx_valid_q) begin
            loading_q <= 1'b0;
            if (rx_byte_q == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: ;  // S_DONE / S_ERROR hold until reset
      endcase
      if (rx_frame_err && (state_q != S_DONE) && (state_q != S_ERROR)) begin
        state_q   <= S_ERROR;
        error_q   <= 1'b1;
        loading_q <= 1'b0;
      end
    end
  end

  assign O_MEM_DATA         = data_q;
  assign O_MEM_ADDRESS      = addr_q;
  assign O_MEM_WRITE_ENABLE = we_q;
  assign O_LOADING          = loading_q;
  assign O_DONE             = done_q;
  assign O_ERROR            = error_q;
  assign O_WORD_COUNT       = wcnt_q;
  assign O_DBG_STATE        = state_q;

endmodule

// File: tb/tb_bram_uart_loader.sv
// Directed bench for bram_uart_loader with a bit period of 10 clocks and a
// 4-bit address space (16-word BRAM) so the full-image/wrap case stays short.
module tb_bram_uart_loader;

  localparam int D  = 10;
  localparam int AW = 4;

  logic          clk;
  logic          nreset;
  logic          rx;
  logic [15:0]   mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          loading;
  logic          done;
  logic          error;
  logic [15:0]   word_count;
  logic [2:0]    dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int width_err = 0;
  logic we_prev = 1'b0;

  // Scoreboard entries are {address, data}.
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] got_q[$];

  bram_uart_loader #(
    .P_CLK_FREQ_HZ  (1000),
    .P_BAUD_RATE    (100),
    .P_DATA_WIDTH   (16),
    .P_ADDRESS_WIDTH(AW)
  ) dut (
    .I_CLK             (clk),
    .I_NRESET          (nreset),
    .I_UART_RX         (rx),
    .O_MEM_DATA        (mem_data),
    .O_MEM_ADDRESS     (mem_addr),
    .O_MEM_WRITE_ENABLE(mem_we),
    .O_LOADING         (loading),
    .O_DONE            (done),
    .O_ERROR           (error),
    .O_WORD_COUNT      (word_count),
    .O_DBG_STATE       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    nreset = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    width_err = 0;
  endtask

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_data});
    if (mem_we && we_prev) width_err++;
    we_prev = mem_we;
  end

  // ---------------- drivers ----------------
  // Starts driving at the current negedge; returns at the end of the stop bit
  // so consecutive calls are back-to-back with no idle time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop_bit;
    repeat (D) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total_cnt++; if (mem_data !== 16'h0) $display("FAIL reset_data got %h want 0000", mem_data); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL reset_addr got %h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (loading !== 1'b0) $display("FAIL reset_loading got %b want 0", loading); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd0) $display("FAIL reset_count got %0d want 0", word_count); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_basic();
    apply_reset();
    exp_q.push_back({4'h0, 16'h1234});
    exp_q.push_back({4'h1, 16'hABCD});
    send_byte(8'h00, 1'b1);
    total_cnt++; if (loading !== 1'b1) $display("FAIL basic_loading_mid got %b want 1", loading); else pass_cnt++;
    send_byte(8'h02, 1'b1);
    send_word(16'h1234);
    send_word(16'hABCD);
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [AW+15:0] e;
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL basic_write missing, want %h", e);
      else begin
        logic [AW+15:0] g;
        g = got_q.pop_front();
        if (g !== e) $display("FAIL basic_write got %h want %h", g, e); else pass_cnt++;
      end
    end
    total_cnt++; if (got_q.size() != 0) $display("FAIL basic_extra_writes got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (width_err != 0) $display("FAIL basic_strobe_width got %0d long pulses want 0", width_err); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL basic_error got %b want 0", error); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd2) $display("FAIL basic_count got %0d want 2", word_count); else pass_cnt++;
    total_cnt++; if (mem_addr !== 4'd2) $display("FAIL basic_addr got %0d want 2", mem_addr); else pass_cnt++;
    total_cnt++; if (loading !== 1'b0) $display("FAIL basic_loading_end got %b want 0", loading); else pass_cnt++;
  endtask

  task automatic test_zero_length();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    // The stop-bit sample sits mid-bit, so done is already up here.
    total_cnt++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if (got_q.size() != 0) $display("FAIL zero_writes got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd0) $display("FAIL zero_count got %0d want 0", word_count); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL zero_error got %b want 0", error); else pass_cnt++;
  endtask

  task automatic test_framing_error();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b0);
    total_cnt++; if (error !== 1'b1) $display("FAIL frame_error got %b want 1", error); else pass_cnt++;
    repeat (2 * D) @(negedge clk);
    send_word(16'h3456);
    send_word(16'h789A);
    repeat (5) @(negedge clk);
    total_cnt++; if (got_q.size() != 0) $display("FAIL frame_writes got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL frame_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (loading !== 1'b0) $display("FAIL frame_loading got %b want 0", loading); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd7) $display("FAIL frame_state got %0d want 7", dbg_state); else pass_cnt++;
  endtask

  task automatic test_length_error();
    apply_reset();
    // 17 words into a 16-word BRAM.
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    total_cnt++; if (error !== 1'b1) $display("FAIL len_error got %b want 1", error); else pass_cnt++;
    send_word(16'h1111);
    repeat (5) @(negedge clk);
    total_cnt++; if (got_q.size() != 0) $display("FAIL len_writes got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL len_done got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_full_image();
    logic [7:0] hb;
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 16; i++) begin
      hb = 8'(i * 17);
      exp_q.push_back({4'(i), hb, ~hb});
      send_word({hb, ~hb});
    end
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [AW+15:0] e;
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL full_write missing, want %h", e);
      else begin
        logic [AW+15:0] g;
        g = got_q.pop_front();
        if (g !== e) $display("FAIL full_write got %h want %h", g, e); else pass_cnt++;
      end
    end
    total_cnt++; if (got_q.size() != 0) $display("FAIL full_extra_writes got %0d want 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL full_done got %b want 1", done); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd16) $display("FAIL full_count got %0d want 16", word_count); else pass_cnt++;
    total_cnt++; if (mem_addr !== 4'd0) $display("FAIL full_addr_wrap got %0d want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (width_err != 0) $display("FAIL full_strobe_width got %0d long pulses want 0", width_err); else pass_cnt++;
  endtask

  task automatic test_glitch();
    apply_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL glitch_state got %0d want 0", dbg_state); else pass_cnt++;
    total_cnt++; if (loading !== 1'b0) $display("FAIL glitch_loading got %b want 0", loading); else pass_cnt++;
    // A real image still loads afterwards, proving the glitch cost no byte.
    exp_q.push_back({4'h0, 16'hC0DE});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(16'hC0DE);
    repeat (5) @(negedge clk);
    total_cnt++;
    if (got_q.size() != 1) $display("FAIL glitch_write_count got %0d want 1", got_q.size());
    else if (got_q[0] !== exp_q[0]) $display("FAIL glitch_write got %h want %h", got_q[0], exp_q[0]);
    else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL glitch_done got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(16'h1234);
    send_byte(8'hAB, 1'b1);
    // Start of the next byte, then reset in the middle of its data bits.
    rx = 1'b0;
    repeat (3 * D) @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (mem_data !== 16'h0) $display("FAIL midrst_data got %h want 0000", mem_data); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd0) $display("FAIL midrst_count got %0d want 0", word_count); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL midrst_addr got %0d want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (loading !== 1'b0) $display("FAIL midrst_loading got %b want 0", loading); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL midrst_state got %0d want 0", dbg_state); else pass_cnt++;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2 * D) @(negedge clk);
    got_q.delete();
    exp_q.push_back({4'h0, 16'h55AA});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(16'h55AA);
    repeat (5) @(negedge clk);
    total_cnt++;
    if (got_q.size() != 1) $display("FAIL midrst_reload_count got %0d want 1", got_q.size());
    else if (got_q[0] !== exp_q[0]) $display("FAIL midrst_reload got %h want %h", got_q[0], exp_q[0]);
    else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL midrst_done got %b want 1", done); else pass_cnt++;
    total_cnt++; if (word_count !== 16'd1) $display("FAIL midrst_reload_cnt got %0d want 1", word_count); else pass_cnt++;
  endtask

`ifdef BRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    // 00 ^ 01 ^ BE ^ EF = 50
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_word(16'hBEEF);
    send_byte(8'h50, 1'b1);
    repeat (3) @(negedge clk);
    total_cnt++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL cks_good got done=%b err=%b want 1/0", done, error); else pass_cnt++;
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_word(16'hBEEF);
    send_byte(8'h51, 1'b1);
    repeat (3) @(negedge clk);
    total_cnt++; if (done !== 1'b0 || error !== 1'b1) $display("FAIL cks_bad got done=%b err=%b want 0/1", done, error); else pass_cnt++;
    total_cnt++;
    if (got_q.size() != 1) $display("FAIL cks_bad_write_count got %0d want 1", got_q.size());
    else if (got_q[0] !== {4'h0, 16'hBEEF}) $display("FAIL cks_bad_write got %h want 0beef", got_q[0]);
    else pass_cnt++;
  endtask
`endif

  initial begin
    nreset = 1'b0;
    rx     = 1'b1;
    test_reset();
`ifndef BRAM_LOADER_CHECKSUM_EN
    test_basic();
    test_zero_length();
    test_framing_error();
    test_length_error();
    test_full_image();
    test_glitch();
    test_reset_mid_word();
`else
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
